// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined SEC-DED (extended Hamming) decoder with valid/ready flow
// control and saturating single/double error counters.
module secded_dec_pipe #(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    localparam int HAM_W  = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 :
                            (DATA_W <= 57) ? 6 : 7,
    localparam int CHK_W  = HAM_W + 1,
    localparam int CW_W   = DATA_W + CHK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW_W-1:0]   out_cw,
    output logic [CHK_W-1:0]  out_syn,
    output logic              out_err,
    output logic              out_sgl,
    output logic              out_dbl,
    output logic [CNT_W-1:0]  cnt_sgl,
    output logic [CNT_W-1:0]  cnt_dbl,
    input  logic              cnt_clr
);

    // Hamming position of the k-th data bit: k-th non-power-of-two index >= 3.
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < CW_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic              s1_valid_q;
    logic [CW_W-1:0]   s1_cw_q;
    logic              s1_corr_q;
    logic [CHK_W-1:0]  s1_syn_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CW_W-1:0]   out_cw_q;
    logic [CHK_W-1:0]  out_syn_q;
    logic              out_err_q;
    logic              out_sgl_q;
    logic              out_dbl_q;
    logic [CNT_W-1:0]  cnt_sgl_q;
    logic [CNT_W-1:0]  cnt_dbl_q;

    logic s2_ready, s1_load, s2_load, out_fire;

    assign s2_ready = ~out_valid_q | out_ready;
    // Held low during reset so nothing is accepted while the pipe is flushed.
    assign in_ready = rst_n & (~s1_valid_q | s2_ready);
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s1_valid_q & s2_ready;
    assign out_fire = out_valid_q & out_ready;

    // ---------------- Stage 1: syndrome ----------------
    logic [HAM_W-1:0] syn_h_d;
    logic             syn_p_d;

    always_comb begin
        syn_h_d = '0;
        for (int i = 1; i < CW_W; i++)
            if (in_cw[i]) syn_h_d = syn_h_d ^ HAM_W'(i);
    end

    assign syn_p_d = ^in_cw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cw_q    <= '0;
            s1_corr_q  <= 1'b0;
            s1_syn_q   <= '0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (s1_load) begin
                s1_cw_q   <= in_cw;
                s1_corr_q <= corr_en;
                s1_syn_q  <= {syn_p_d, syn_h_d};
            end
        end
    end

    // ---------------- Stage 2: classify and correct ----------------
    logic              s1_p;
    logic [HAM_W-1:0]  s1_s;
    logic              in_range, sgl_d, dbl_d, fix_d;
    logic [CW_W-1:0]   cw_d;
    logic [DATA_W-1:0] data_d;

    assign s1_p     = s1_syn_q[HAM_W];
    assign s1_s     = s1_syn_q[HAM_W-1:0];
    assign in_range = (s1_s <= HAM_W'(CW_W - 1));
    assign sgl_d    = s1_p & in_range;
    assign dbl_d    = s1_p ? ~in_range : (s1_s != '0);
    assign fix_d    = sgl_d & s1_corr_q;

    // s == 0 with p == 1 addresses the overall parity bit, so one rule covers both.
    always_comb begin
        cw_d = s1_cw_q;
        for (int i = 0; i < CW_W; i++)
            if (fix_d && (s1_s == HAM_W'(i))) cw_d[i] = ~s1_cw_q[i];
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_extract
        localparam int POS = data_pos(k);
        assign data_d[k] = cw_d[POS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cw_q    <= '0;
            out_syn_q   <= '0;
            out_err_q   <= 1'b0;
            out_sgl_q   <= 1'b0;
            out_dbl_q   <= 1'b0;
        end else begin
            if (s2_ready) out_valid_q <= s1_valid_q;
            if (s2_load) begin
                out_data_q <= data_d;
                out_cw_q   <= cw_d;
                out_syn_q  <= s1_syn_q;
                out_err_q  <= sgl_d | dbl_d;
                out_sgl_q  <= sgl_d;
                out_dbl_q  <= dbl_d;
            end
        end
    end

    // ---------------- Error statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_sgl_q <= '0;
            cnt_dbl_q <= '0;
        end else if (cnt_clr) begin
            cnt_sgl_q <= '0;
            cnt_dbl_q <= '0;
        end else if (out_fire) begin
            if (out_sgl_q && (cnt_sgl_q != '1)) cnt_sgl_q <= cnt_sgl_q + 1'b1;
            if (out_dbl_q && (cnt_dbl_q != '1)) cnt_dbl_q <= cnt_dbl_q + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cw    = out_cw_q;
    assign out_syn   = out_syn_q;
    assign out_err   = out_err_q;
    assign out_sgl   = out_sgl_q;
    assign out_dbl   = out_dbl_q;
    assign cnt_sgl   = cnt_sgl_q;
    assign cnt_dbl   = cnt_dbl_q;

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Scoreboard bench for secded_dec_pipe (DATA_W=32); a second instance with
// CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_secded_dec_pipe;

    typedef struct {
        logic [31:0] d;
        logic [38:0] cw;
        logic [6:0]  syn;
        logic        sgl;
        logic        dbl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, corr_en, out_valid, out_ready, cnt_clr;
    logic [38:0] in_cw, out_cw;
    logic [31:0] out_data;
    logic [6:0]  out_syn;
    logic        out_err, out_sgl, out_dbl;
    logic [15:0] cnt_sgl, cnt_dbl;

    logic        b_in_ready, b_out_valid, b_out_err, b_out_sgl, b_out_dbl;
    logic [38:0] b_out_cw;
    logic [31:0] b_out_data;
    logic [6:0]  b_out_syn;
    logic [1:0]  b_cnt_sgl, b_cnt_dbl;

    exp_t expq[$];
    int   npass = 0;
    int   ntot  = 0;
    int   nout  = 0;
    int   or_mode = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    secded_dec_pipe #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cw(in_cw), .corr_en(corr_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cw(out_cw), .out_syn(out_syn), .out_err(out_err),
        .out_sgl(out_sgl), .out_dbl(out_dbl), .cnt_sgl(cnt_sgl), .cnt_dbl(cnt_dbl),
        .cnt_clr(cnt_clr)
    );

    secded_dec_pipe #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_cw(in_cw), .corr_en(corr_en), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_cw(b_out_cw), .out_syn(b_out_syn), .out_err(b_out_err),
        .out_sgl(b_out_sgl), .out_dbl(b_out_dbl), .cnt_sgl(b_cnt_sgl), .cnt_dbl(b_cnt_dbl),
        .cnt_clr(cnt_clr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference encoder for the random stream.
    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [38:0] c;
        logic        b;
        int          k;
        c = '0;
        k = 0;
        for (int i = 3; i < 39; i++)
            if ((i & (i - 1)) != 0) begin
                c[i] = d[k];
                k++;
            end
        for (int j = 0; j < 6; j++) begin
            b = 1'b0;
            for (int i = 1; i < 39; i++)
                if (((i >> j) & 1) == 1) b = b ^ c[i];
            c[1 << j] = b;
        end
        c[0] = ^c[38:1];
        return c;
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic [38:0] cw,
                                input logic [6:0] syn, input logic sgl, input logic dbl);
        exp_t e;
        e.d = d; e.cw = cw; e.syn = syn; e.sgl = sgl; e.dbl = dbl;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [38:0] cw, input logic ce, input exp_t e);
        int n;
        n = 0;
        in_cw = cw; corr_en = ce; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        else expq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        chk("drain_empty", 64'(expq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_cnt();
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (or_mode == 0) out_ready = 1'b1;
            else if (or_mode == 1) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        end
    end

    // Monitor: checks each output transfer and stability across stalls.
    initial begin
        exp_t        e;
        logic        stall;
        logic [38:0] h_cw;
        logic [41:0] h_rest;
        stall = 1'b0; h_cw = '0; h_rest = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall && out_valid) begin
                chk("hold_cw", 64'(out_cw), 64'(h_cw));
                chk("hold_rest", 64'({out_syn, out_sgl, out_dbl, out_data}), 64'(h_rest));
            end
            if (out_valid && out_ready) begin
                nout++;
                if (expq.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("data", 64'(out_data), 64'(e.d));
                    chk("cw", 64'(out_cw), 64'(e.cw));
                    chk("syn", 64'(out_syn), 64'(e.syn));
                    chk("flags", 64'({out_err, out_sgl, out_dbl}),
                        64'({e.sgl | e.dbl, e.sgl, e.dbl}));
                end
            end
            stall  = out_valid && !out_ready;
            h_cw   = out_cw;
            h_rest = {out_syn, out_sgl, out_dbl, out_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [38:0] c;
        int          pos, n, base;

        rst_n = 1'b0; in_valid = 1'b0; in_cw = '0; corr_en = 1'b1; cnt_clr = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_outs", 64'({out_data, out_syn, out_err, out_sgl, out_dbl}), 64'd0);
        chk("rst_cnts", 64'({cnt_sgl, cnt_dbl}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed vectors
        send(39'h0, 1'b1, mk(32'h0, 39'h0, 7'h00, 1'b0, 1'b0));
        send(39'h7, 1'b1, mk(32'h1, 39'hF, 7'h43, 1'b1, 1'b0));
        send(39'h7, 1'b0, mk(32'h0, 39'h7, 7'h43, 1'b1, 1'b0));
        send(39'h27, 1'b1, mk(32'h2, 39'h27, 7'h06, 1'b0, 1'b1));
        send(39'h1, 1'b1, mk(32'h0, 39'h0, 7'h40, 1'b1, 1'b0));
        send(39'h1_0000_0081, 1'b1, mk(32'h8, 39'h1_0000_0081, 7'h67, 1'b0, 1'b1));
        send(39'hF, 1'b1, mk(32'h1, 39'hF, 7'h00, 1'b0, 1'b0));
        drain();
        chk("cnt_sgl_dir", 64'(cnt_sgl), 64'd3);
        chk("cnt_dbl_dir", 64'(cnt_dbl), 64'd2);
        chk("sat_cnt_sgl_dir", 64'(b_cnt_sgl), 64'd3);

        // Backpressure stream of single-error words
        clear_cnt();
        chk("cnt_clr_idle", 64'({cnt_sgl, cnt_dbl}), 64'd0);
        base = nout;
        or_mode = 1;
        for (int w = 0; w < 8; w++) begin
            d   = $urandom;
            pos = $urandom_range(0, 38);
            c   = enc(d);
            send(c ^ (39'd1 << pos), 1'b1, mk(d, c, {1'b1, 6'(pos)}, 1'b1, 1'b0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        or_mode = 0;
        chk("stream_count", 64'(nout - base), 64'd8);
        chk("cnt_sgl_stream", 64'(cnt_sgl), 64'd8);

        // Saturation with a 2-bit counter
        clear_cnt();
        for (int w = 0; w < 5; w++)
            send(39'h27, 1'b1, mk(32'h2, 39'h27, 7'h06, 1'b0, 1'b1));
        drain();
        chk("sat_cnt_dbl", 64'(b_cnt_dbl), 64'd3);
        chk("cnt_dbl_5", 64'(cnt_dbl), 64'd5);

        // Clear coincident with an SGL transfer
        send(39'h7, 1'b1, mk(32'h1, 39'hF, 7'h43, 1'b1, 1'b0));
        drain();
        chk("cnt_sgl_1", 64'(cnt_sgl), 64'd1);
        or_mode = 2;
        out_ready = 1'b0;
        send(39'h1, 1'b1, mk(32'h0, 39'h0, 7'h40, 1'b1, 1'b0));
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk); n++;
        end
        chk("clr_wait_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("clr_wins_sgl", 64'(cnt_sgl), 64'd0);
        chk("clr_wins_dbl", 64'(cnt_dbl), 64'd0);
        chk("clr_wins_sat", 64'({b_cnt_sgl, b_cnt_dbl}), 64'd0);
        chk("clr_queue", 64'(expq.size()), 64'd0);
        @(negedge clk);
        or_mode = 0;

        // Reset with words in flight
        send(39'h27, 1'b1, mk(32'h2, 39'h27, 7'h06, 1'b0, 1'b1));
        drain();
        chk("cnt_dbl_pre_rst", 64'(cnt_dbl), 64'd1);
        or_mode = 2;
        out_ready = 1'b0;
        send(39'h0, 1'b1, mk(32'h0, 39'h0, 7'h00, 1'b0, 1'b0));
        send(39'h7, 1'b1, mk(32'h1, 39'hF, 7'h43, 1'b1, 1'b0));
        chk("inflight_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        expq.delete();
        chk("rst_fl_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fl_cnts", 64'({cnt_sgl, cnt_dbl}), 64'd0);
        chk("rst_fl_data", 64'({out_data, out_syn, out_sgl, out_dbl}), 64'd0);
        chk("rst_fl_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        base = nout;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (out_valid) n++;
        end
        chk("no_stale_word", 64'(n), 64'd0);
        or_mode = 0;
        @(negedge clk);
        send(39'hF, 1'b0, mk(32'h1, 39'hF, 7'h00, 1'b0, 1'b0));
        drain();
        chk("post_rst_outputs", 64'(nout - base), 64'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/secded_dec_pipe.md
Name: secded_dec_pipe

Overview:
- Parametrised, pipelined SEC-DED (extended Hamming) decoder with valid/ready flow control and saturating error-statistics counters.
- Successor to the fixed 32-bit combinational decoder.
- Sits between memory read data and the consumer.
- Corrects single-bit errors, flags double-bit errors, and reports the syndrome.

Parameters:
- DATA_W, 32: data bits per word; legal range 4..64.
- HAM_W, derived: smallest r with 2^r >= DATA_W+r+1 (6 for DATA_W=32). Localparam, not overridable.
- CHK_W, derived: HAM_W+1 (7 for DATA_W=32).
- CW_W, derived: DATA_W+CHK_W (39 for DATA_W=32).
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  input codeword valid
- in_ready  out  1  decoder can accept a codeword
- in_cw  in  CW_W  received codeword
- corr_en  in  1  1 = correct single errors; 0 = detect only, data passed raw
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  extracted (corrected) data
- out_cw  out  CW_W  corrected codeword (raw when corr_en=0 or DBL)
- out_syn  out  CHK_W  {overall parity, Hamming syndrome}
- out_err  out  1  any error detected
- out_sgl  out  1  single-bit error
- out_dbl  out  1  double-bit or uncorrectable error
- cnt_sgl  out  CNT_W  accepted results with out_sgl=1
- cnt_dbl  out  CNT_W  accepted results with out_dbl=1
- cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Codeword layout:
  - in_cw[0] = overall even parity over all CW_W bits.
  - Bits 1..CW_W-1 use Hamming positions; check bits sit at power-of-two positions (1,2,4,...).
  - Data bits fill the remaining positions in ascending order, data[0] at the lowest (position 3).
- Syndrome:
  - s = XOR of the indices of all set bits in positions 1..CW_W-1.
  - p = XOR of all CW_W bits.
  - out_syn = {p, s}.
- Classification:
  - p=0, s=0: no error.
  - p=1, s=0: single error in bit 0.
  - p=1, 0<s<=CW_W-1: single error at position s.
  - p=1, s>CW_W-1: out_dbl=1, out_sgl=0.
  - p=0, s!=0: out_dbl=1.
  - out_err = out_sgl | out_dbl.
- Correction:
  - Applied only when out_sgl=1 and corr_en=1; flips bit s (or bit 0).
  - Flags and syndrome are reported regardless of corr_en.
  - When corr_en=0 or out_dbl=1, out_data and out_cw carry raw received bits.
- Pipeline: two register stages.
  - S1 captures in_cw, corr_en, and the syndrome.
  - S2 captures corrected data, cw, and flags.
  - Latency: 2 cycles from input handshake to out_valid with no stall.
  - Throughput: 1 word/cycle.
- Handshake:
  - s2_ready = ~s2_valid | out_ready; in_ready = ~s1_valid | s2_ready (combinational chain).
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - out_* data and flags hold stable while out_valid=1 and out_ready=0.
  - No word is dropped or duplicated under any valid/ready pattern.
- Counters:
  - cnt_sgl increments on an output transfer with out_sgl=1; cnt_dbl likewise with out_dbl=1.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr zeroes both; clear wins over a same-cycle increment, and that event is not counted.
- Reset:
  - rst_n low immediately clears s1_valid, s2_valid, out_valid, in_ready, both counters, and all out_* data, flag and syndrome registers to 0.
  - In-flight words are discarded.
  - After rst_n deasserts, in_ready=1 on the first cycle.
- X handling: out_* content is don't-care when out_valid=0, but still reset to 0.

Test Plan:
- DATA_W=32, in_cw=39'h0, corr_en=1 -> 2 cycles later out_valid=1, out_data=0, out_syn=7'h00, err/sgl/dbl=0.
- in_cw=39'h7 (data 1 with bit 3 flipped; clean word 39'hF), corr_en=1 -> out_data=32'h1, out_cw=39'hF, out_syn=7'h43, out_sgl=1. Repeat with corr_en=0 -> out_data=32'h0, out_sgl=1.
- in_cw=39'h27 (bits 3 and 5 flipped) -> out_dbl=1, out_syn=7'h06, out_cw=39'h27. in_cw=39'h1 -> out_sgl=1, out_syn=7'h40, out_data=0.
- Out-of-range syndrome:
  - Stimulus: in_cw with bits 0, 7 and 32 set.
  - Response: s=39, out_syn=7'h67, out_dbl=1, out_sgl=0.
- Backpressure:
  - Stimulus: stream 8 words with random single errors; out_ready toggled 1,0,0,1,...; in_valid random.
  - Response: all 8 results delivered in order and corrected; data stable during stalls; cnt_sgl=8.
- Counters and reset:
  - Stimulus: CNT_W=2; 5 DBL words accepted.
  - Response: cnt_dbl=3 (saturated).
  - Stimulus: cnt_clr asserted in the same cycle as an out_sgl transfer.
  - Response: cnt_sgl=0.
  - Stimulus: rst_n low while 2 words are in flight.
  - Response: out_valid=0 and counters=0 immediately; no stale word emerges after release.
